// File: rtl/uart_pkg.sv
// uart_pkg: UART framing constants and RX state encoding shared by the RX and TX paths.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser; mirror of uart_tx.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       serial_in,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx;

    assign rx = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], serial_in};
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx && enable) state_d = START;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {rx, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == LAST_BIT) state_d = STOP;
            end
            STOP: if (cnt_q == FULL) begin
                state_d = IDLE;
                valid_d = rx;
                ferr_d  = !rx;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_byte        = shift_q;
    assign o_valid       = valid_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = state_q != IDLE;
endmodule

// File: rtl/write_input_controller.sv
// write_input_controller: packs received UART bytes LSB-first into words and
// writes them to memory at an auto-incrementing address.
module write_input_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              serial_in,
    input  logic [ADDR_W-1:0] i_start_address,
    input  logic              i_load_address,
    output logic              o_mem_enable,
    output logic              o_mem_readWrite,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_dataIn,
    output logic              o_word_done,
    output logic              o_frame_error,
    output logic              o_busy
);
    logic [7:0]        rx_byte;
    logic              rx_valid, rx_busy, done;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d, word_ins;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic              en_q, en_d;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .serial_in    (serial_in),
        .o_byte       (rx_byte),
        .o_valid      (rx_valid),
        .o_frame_error(o_frame_error),
        .o_busy       (rx_busy)
    );

    // A load coinciding with completion still writes at the old pointer via wr_addr_q.
    always_comb begin
        done     = rx_valid && idx_q == 2'(BYTES_PER_WORD - 1);
        word_ins = word_q;
        word_ins[{idx_q, 3'b000} +: 8] = rx_byte;
        word_d    = i_load_address ? '0 : rx_valid ? word_ins : word_q;
        idx_d     = i_load_address ? 2'd0 : rx_valid ? idx_q + 1'b1 : idx_q;
        en_d      = done;
        data_d    = done ? word_ins : data_q;
        wr_addr_d = done ? ptr_q : wr_addr_q;
        ptr_d     = i_load_address ? i_start_address : done ? ptr_q + 1'b1 : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx_q     <= '0;
            word_q    <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            en_q      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            word_q    <= word_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            en_q      <= en_d;
        end
    end

    assign o_mem_enable    = en_q;
    assign o_word_done     = en_q;
    assign o_mem_readWrite = !en_q;
    assign o_mem_address   = en_q ? wr_addr_q : ptr_q;
    assign o_mem_dataIn    = data_q;
    assign o_busy          = rx_busy || rx_valid || idx_q != 2'd0;
endmodule

// File: tb/tb_write_input_controller.sv
// tb_write_input_controller: table-driven word writes plus framing, glitch, reset,
// enable and load-collision sequences, checked through a write scoreboard.
module tb_write_input_controller;
    localparam int CPB = 8;

    typedef struct {
        logic        ld;
        logic [7:0]  sa;
        logic [31:0] word;
        logic [7:0]  ea;
    } vec_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        rw;
        logic        dn;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        serial_in = 1'b1;
    logic [7:0]  i_start_address = '0;
    logic        i_load_address = 1'b0;
    logic        o_mem_enable, o_mem_readWrite, o_word_done, o_frame_error, o_busy;
    logic [7:0]  o_mem_address;
    logic [31:0] o_mem_dataIn;

    int  n_vec = 0;
    int  n_err = 0;
    int  fe_cnt = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    vec_t vt[6];

    write_input_controller #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .DATA_W(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .serial_in      (serial_in),
        .i_start_address(i_start_address),
        .i_load_address (i_load_address),
        .o_mem_enable   (o_mem_enable),
        .o_mem_readWrite(o_mem_readWrite),
        .o_mem_address  (o_mem_address),
        .o_mem_dataIn   (o_mem_dataIn),
        .o_word_done    (o_word_done),
        .o_frame_error  (o_frame_error),
        .o_busy         (o_busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (o_mem_enable) obs_q.push_back('{o_mem_address, o_mem_dataIn, o_mem_readWrite, o_word_done});
        if (o_frame_error) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clock);
        end
        serial_in = stop;
        repeat (CPB) @(negedge clock);
        serial_in = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic load(input logic [7:0] a);
        i_start_address = a;
        i_load_address  = 1'b1;
        @(negedge clock);
        i_load_address  = 1'b0;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back('{a, d, 1'b0, 1'b1});
    endtask

    task automatic drain();
        int  t = 0;
        wr_t e, o;
        while (obs_q.size() < exp_q.size() && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (obs_q.size() < exp_q.size()) chk("write timeout", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("write addr", {24'h0, o.a}, {24'h0, e.a});
            chk("write data", o.d, e.d);
            chk("readWrite", {31'h0, o.rw}, {31'h0, e.rw});
            chk("word_done", {31'h0, o.dn}, {31'h0, e.dn});
        end
        exp_q.delete();
    endtask

    initial begin
        vt[0] = '{1'b1, 8'h10, 32'h12345678, 8'h10};
        vt[1] = '{1'b1, 8'hFF, 32'h04030201, 8'hFF};
        vt[2] = '{1'b0, 8'h00, 32'h08070605, 8'h00};
        vt[3] = '{1'b0, 8'h00, 32'hDEADBEEF, 8'h01};
        vt[4] = '{1'b1, 8'h80, 32'h00000000, 8'h80};
        vt[5] = '{1'b0, 8'h00, 32'hFFFFFFFF, 8'h81};

        repeat (3) @(negedge clock);
        chk("reset mem_enable", {31'h0, o_mem_enable}, 32'h0);
        chk("reset readWrite", {31'h0, o_mem_readWrite}, 32'h1);
        chk("reset address", {24'h0, o_mem_address}, 32'h0);
        chk("reset dataIn", o_mem_dataIn, 32'h0);
        chk("reset word_done", {31'h0, o_word_done}, 32'h0);
        chk("reset frame_error", {31'h0, o_frame_error}, 32'h0);
        chk("reset busy", {31'h0, o_busy}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            if (vt[i].ld) load(vt[i].sa);
            expect_wr(vt[i].ea, vt[i].word);
            send_word(vt[i].word);
            drain();
            chk("next pointer", {24'h0, o_mem_address}, {24'h0, 8'(vt[i].ea + 8'd1)});
        end

        expect_wr(8'h82, 32'hEEDDCCAA);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        drain();
        chk("frame_error pulses", 32'(fe_cnt), 32'd1);

        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        serial_in = 1'b1;
        repeat (16) @(negedge clock);
        chk("glitch busy", {31'h0, o_busy}, 32'h0);
        chk("glitch writes", 32'(obs_q.size()), 32'd0);
        chk("glitch frame_error", 32'(fe_cnt), 32'd1);
        expect_wr(8'h83, 32'h11223344);
        send_word(32'h11223344);
        drain();

        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (30) @(negedge clock);
                reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end
        join
        chk("mid-reset busy", {31'h0, o_busy}, 32'h0);
        chk("mid-reset pointer", {24'h0, o_mem_address}, 32'h0);
        expect_wr(8'h00, 32'h44332211);
        send_word(32'h44332211);
        drain();

        enable = 1'b0;
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clock);
        chk("disabled busy", {31'h0, o_busy}, 32'h0);
        chk("disabled writes", 32'(obs_q.size()), 32'd0);
        expect_wr(8'h01, 32'h44332211);
        fork
            send_byte(8'h11, 1'b1);
            begin
                @(negedge clock);
                enable = 1'b1;
            end
        join
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        drain();

        expect_wr(8'h02, 32'hA1B2C3D4);
        send_byte(8'hD4, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hB2, 1'b1);
        fork
            send_byte(8'hA1, 1'b1);
            begin
                repeat (79) @(negedge clock);
                i_start_address = 8'h40;
                i_load_address  = 1'b1;
                @(negedge clock);
                i_load_address  = 1'b0;
            end
        join
        drain();
        chk("load at completion pointer", {24'h0, o_mem_address}, 32'h40);
        expect_wr(8'h40, 32'h0BADF00D);
        send_word(32'h0BADF00D);
        drain();

        repeat (50) @(negedge clock);
        chk("unexpected writes", 32'(obs_q.size()), 32'd0);
        chk("total frame_error pulses", 32'(fe_cnt), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/write_input_controller.md
# write_input_controller

Receive-side counterpart of the memory-to-UART readout path. It deserialises 8N1 UART bytes from `serial_in` and packs four consecutive bytes into one 32-bit word, least-significant byte first. It writes each completed word into the shared `memory` block at an auto-incrementing 8-bit address. The byte order is exactly the order the readout path transmits, so a dumped memory image can be replayed back into memory unchanged.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit; minimum 4.
- `ADDR_W`, 8, memory address width.
- `DATA_W`, 32, memory word width; must equal 4×8.
- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  permits new frames to start; sampled only in `IDLE`.
- `serial_in`  in  1  UART line; idle high, LSB first.
- `i_start_address`  in  ADDR_W  value loaded into the address pointer.
- `i_load_address`  in  1  one-cycle pulse: pointer ← `i_start_address`, partial word discarded.
- `o_mem_enable`  out  1  one-cycle write strobe to `memory.enable`.
- `o_mem_readWrite`  out  1  0 during the write strobe, 1 otherwise.
- `o_mem_address`  out  ADDR_W  write address; stable while the strobe is high.
- `o_mem_dataIn`  out  DATA_W  assembled word.
- `o_word_done`  out  1  pulses with `o_mem_enable`.
- `o_frame_error`  out  1  one-cycle pulse when a stop bit is sampled low.
- `o_busy`  out  1  high while the RX FSM is outside `IDLE`, or a partial word is held.

## Operation
- `serial_in` passes through a 2-flop synchroniser. All line decisions use the synchronised value.
- RX FSM states: `IDLE`, `START`, `DATA`, `STOP`.
- `IDLE` → `START` on a synchronised low while `enable`=1.
- `START`: sample at count `CLKS_PER_BIT/2`.
  - Low → `DATA`, counter restarts.
  - High → glitch; return to `IDLE` with no byte produced.
- `DATA`: sample every `CLKS_PER_BIT` cycles, 8 bits, shifting LSB first. Then → `STOP`.
- `STOP`: sample after `CLKS_PER_BIT` cycles.
  - High → byte valid.
  - Low → `o_frame_error` pulse; byte discarded; `byte_index` unchanged.
  - Either way, return to `IDLE` on the same edge.
- `enable` deasserted mid-frame does not abort the frame; the current byte completes.
- Assembler: a valid byte is written to `word[8*byte_index +: 8]`, then `byte_index` increments (2 bits).
  - When `byte_index`=3 accepts a byte, the word is complete and `byte_index` wraps to 0.
- Write: on the cycle after completion, drive `o_mem_enable`=1, `o_mem_readWrite`=0, `o_mem_dataIn`=word and `o_mem_address`=pointer, for exactly one cycle.
  - Then pointer ← pointer+1, modulo 2^ADDR_W (0xFF → 0x00).
- `i_load_address` coinciding with word completion:
  - The completed word is still written at the pre-load pointer.
  - The pointer then takes `i_start_address` and is not incremented.
  - `byte_index` returns to 0.
- Reset (any time, including mid-frame):
  - FSM → `IDLE`; counters, `byte_index`, word and pointer → 0.
  - `o_mem_enable`=0, `o_mem_readWrite`=1, `o_mem_address`=0, `o_mem_dataIn`=0, `o_word_done`=0, `o_frame_error`=0, `o_busy`=0.

## Timing
- Synchroniser latency: 2 cycles from a pin edge to FSM visibility.
- Start-bit falling edge (synchronised) to the stop-bit sample: `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles.
- Byte valid is internal and is asserted on the stop-sample edge.
- `o_frame_error` pulses on the stop-sample edge.
- `o_mem_enable` and `o_word_done` assert on the edge after the 4th byte is valid, and are high for exactly 1 cycle.
- The address increment is visible the cycle after the strobe.
- Back-to-back frames: a new start bit may be detected on the cycle after the stop sample, so a minimum stop length of 1 bit is supported.
- The write strobe never overlaps a following write: 4 bytes take ≥ 40×`CLKS_PER_BIT` cycles.

## Structure
- Package `uart_pkg`:
  - RX state enum (`IDLE`, `START`, `DATA`, `STOP`).
  - Constants `UART_DATA_BITS`=8 and `BYTES_PER_WORD`=4.
  - Shared with the TX side.
- Sub-module `uart_rx`: synchroniser, FSM, bit counter and shift register. Outputs `o_byte`, `o_valid` and `o_frame_error`; mirror of `uart_tx`.
- `write_input_controller` holds the assembler, pointer and write-strobe registers, and instantiates `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
- Load 0x10; send 0x78, 0x56, 0x34, 0x12 → exactly one strobe with address 0x10, data 0x12345678 and `o_mem_readWrite`=0; next pointer is 0x11.
- Load 0xFF; send 8 bytes (0x01..0x08) → writes 0x04030201 @0xFF, then 0x08070605 @0x00.
- Send 0xAA, then byte 0xBB with its stop bit held low, then 0xCC, 0xDD, 0xEE → one `o_frame_error` pulse; single write of 0xEEDDCCAA.
- Drive a 3-cycle low glitch on an idle line → no byte, no error, `o_busy` returns to 0; the next 4 valid bytes write normally.
- Send 2 bytes, assert `reset_n`=0 for 1 cycle mid-3rd-byte, then send 0x11, 0x22, 0x33, 0x44 → single write 0x44332211 @0x00.
- Hold `enable`=0 and send a frame → no activity. Raise `enable` mid-start-bit of the next frame → that frame is ignored until the line idles, or is received if the low is first seen while `enable`=1.
